mem_lsu: RTL and testbench

Memory-stage load/store unit for the pipelined RV32IM core. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register, and is the producer of the MEM/WB `mem_data_in` value. It converts a load or store from EX/MEM into a valid/ready data-bus transaction and aligns, masks and sign-extends load data. It holds the pipeline stalled until the transaction completes.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/mem_lsu_if.sv | 30 +++
 rtl/lsu_align.sv | 62 ++++++
 rtl/mem_lsu.sv | 173 +++++++++++++++++
 tb/tb_mem_lsu.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32IM core's memory stage.
//   F3_*         : funct3 encodings of loads and stores. Store codes reuse the
//                  low-half load codes (SB=LB, SH=LH, SW=LW).
//   lsu_state_t  : load/store unit transaction state.
package riscv_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2,
      LSU_DONE = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/mem_lsu_if.sv
// Valid/ready data-bus between the load/store unit (master) and memory (slave).
//   req_valid/req_ready : request handshake
//   req_addr            : word-aligned byte address
//   req_we              : 1 = write
//   req_wstrb/req_wdata : byte enables and lane-replicated write data
//   rsp_valid/rsp_rdata : read response (no back-pressure)
interface mem_lsu_if #(
   parameter int ADDR_W = 32
) ();

   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              req_we;
   logic [3:0]        req_wstrb;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;

   modport master (
      output req_valid, req_addr, req_we, req_wstrb, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_addr, req_we, req_wstrb, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/lsu_align.sv
// Purely combinational lane logic for the load/store unit.
//   funct3_i, addr_lo_i : access type and byte offset within the word
//   is_store_i          : enables strobe/write-data generation
//   store_data_i        : rs2 value   -> wstrb_o, wdata_o (lane-replicated)
//   rdata_i             : bus word    -> ldata_o (selected, extended)
//   misalign_o          : half not on a 2-byte or word not on a 4-byte boundary
module lsu_align
   import riscv_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        is_store_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   output logic [31:0] ldata_o,
   output logic        misalign_o
);

   // Bring the addressed byte/half down to bit 0 so extraction is lane-agnostic.
   logic [31:0] shifted;
   assign shifted = rdata_i >> {addr_lo_i, 3'b000};

   // Store encodings alias the load ones, so the case is written in load terms;
   // funct3[2] set is never a legal store and produces no strobes.
   always_comb begin
      wstrb_o    = 4'b0000;
      wdata_o    = '0;
      ldata_o    = '0;
      misalign_o = 1'b0;
      case (funct3_i)
         F3_LB, F3_LBU: begin
            ldata_o = (funct3_i == F3_LB) ? {{24{shifted[7]}}, shifted[7:0]}
                                          : {24'h0, shifted[7:0]};
            if (is_store_i && !funct3_i[2]) begin
               wstrb_o = 4'b0001 << addr_lo_i;
               wdata_o = {4{store_data_i[7:0]}};
            end
         end
         F3_LH, F3_LHU: begin
            misalign_o = addr_lo_i[0];
            ldata_o    = (funct3_i == F3_LH) ? {{16{shifted[15]}}, shifted[15:0]}
                                             : {16'h0, shifted[15:0]};
            if (is_store_i && !funct3_i[2]) begin
               wstrb_o = 4'b0011 << addr_lo_i;
               wdata_o = {2{store_data_i[15:0]}};
            end
         end
         F3_LW: begin
            misalign_o = |addr_lo_i;
            ldata_o    = shifted;
            if (is_store_i) begin
               wstrb_o = 4'b1111;
               wdata_o = store_data_i;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit. Turns an EX/MEM load/store into one valid/ready
// bus transaction, stalls the pipeline until it completes, and formats load
// data for MEM/WB.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   op_valid, mem_read, mem_write   : EX/MEM instruction qualifiers
//   funct3, addr, store_data        : access type, byte address, rs2 value
//   stall                           : pipeline freeze (combinational)
//   misalign                        : pulse on a misaligned access
//   mem_data                        : registered load result
//   bus                             : data-bus master port
module mem_lsu
   import riscv_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              op_valid,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       store_data,
   output logic              stall,
   output logic              misalign,
   output logic [31:0]       mem_data,
   mem_lsu_if.master         bus
);

   lsu_state_t        state_q, state_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic              req_we_q, req_we_d;
   logic [3:0]        req_wstrb_q, req_wstrb_d;
   logic [31:0]       req_wdata_q, req_wdata_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        addr_lo_q, addr_lo_d;
   logic [31:0]       mem_data_q, mem_data_d;
   logic              req_valid;

   logic [3:0]  st_wstrb, ld_wstrb;
   logic [31:0] st_wdata, ld_wdata;
   logic [31:0] st_ldata, ld_ldata;
   logic        st_misalign, ld_misalign;

   // Gated by rst_n so stall/misalign read 0 while reset is held, even if the
   // EX/MEM register still presents a memory op.
   logic mem_op;
   assign mem_op = rst_n & op_valid & (mem_read | mem_write);

   // Store path: works on the live EX/MEM op to build the request and the
   // misalign check before the transaction is accepted.
   lsu_align u_store_align (
      .funct3_i     (funct3),
      .addr_lo_i    (addr[1:0]),
      .is_store_i   (mem_write),
      .store_data_i (store_data),
      .rdata_i      ('0),
      .wstrb_o      (st_wstrb),
      .wdata_o      (st_wdata),
      .ldata_o      (st_ldata),
      .misalign_o   (st_misalign)
   );

   // Load path: works on the latched access so the response is formatted
   // correctly regardless of what EX/MEM presents.
   lsu_align u_load_align (
      .funct3_i     (funct3_q),
      .addr_lo_i    (addr_lo_q),
      .is_store_i   (1'b0),
      .store_data_i ('0),
      .rdata_i      (bus.rsp_rdata),
      .wstrb_o      (ld_wstrb),
      .wdata_o      (ld_wdata),
      .ldata_o      (ld_ldata),
      .misalign_o   (ld_misalign)
   );

   always_comb begin
      // NOTE: every combinational output and next-state value is defaulted
      // first, so no path through the case statement can infer a latch.
      state_d     = state_q;
      req_addr_d  = req_addr_q;
      req_we_d    = req_we_q;
      req_wstrb_d = req_wstrb_q;
      req_wdata_d = req_wdata_q;
      funct3_d    = funct3_q;
      addr_lo_d   = addr_lo_q;
      mem_data_d  = mem_data_q;
      stall       = 1'b0;
      misalign    = 1'b0;
      req_valid   = 1'b0;

      case (state_q)
         LSU_IDLE: begin
            if (mem_op) begin
               if (st_misalign) begin
                  misalign = 1'b1;
               end else begin
                  stall       = 1'b1;
                  state_d     = LSU_REQ;
                  req_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                  req_we_d    = mem_write;
                  req_wstrb_d = st_wstrb;
                  req_wdata_d = st_wdata;
                  funct3_d    = funct3;
                  addr_lo_d   = addr[1:0];
               end
            end
         end
         LSU_REQ: begin
            req_valid = 1'b1;
            stall     = 1'b1;
            if (bus.req_ready) begin
               state_d = req_we_q ? LSU_DONE : LSU_WAIT;
            end
         end
         LSU_WAIT: begin
            stall = 1'b1;
            if (bus.rsp_valid) begin
               mem_data_d = ld_ldata;
               state_d    = LSU_DONE;
            end
         end
         LSU_DONE: begin
            state_d = LSU_IDLE;
         end
         default: begin
            state_d = LSU_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LSU_IDLE;
         req_addr_q  <= '0;
         req_we_q    <= 1'b0;
         req_wstrb_q <= 4'b0000;
         req_wdata_q <= '0;
         funct3_q    <= 3'b000;
         addr_lo_q   <= 2'b00;
         mem_data_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments make every register sample the
         // pre-edge values, independent of statement order.
         state_q     <= state_d;
         req_addr_q  <= req_addr_d;
         req_we_q    <= req_we_d;
         req_wstrb_q <= req_wstrb_d;
         req_wdata_q <= req_wdata_d;
         funct3_q    <= funct3_d;
         addr_lo_q   <= addr_lo_d;
         mem_data_q  <= mem_data_d;
      end
   end

   // The load-path instance only ever sees an access that already passed the
   // misalign check and never writes; the store-path instance never sees bus
   // data. Their remaining outputs are therefore constant.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (ld_wstrb == 4'b0000 && ld_wdata == '0 && !ld_misalign && st_ldata == '0);
      end
   end

   assign bus.req_valid = req_valid;
   assign bus.req_addr  = req_addr_q;
   assign bus.req_we    = req_we_q;
   assign bus.req_wstrb = req_wstrb_q;
   assign bus.req_wdata = req_wdata_q;
   assign mem_data      = mem_data_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Testbench for mem_lsu: directed cases followed by randomized loads/stores,
// checked against a byte-level memory model with a bus slave of its own.
module tb_mem_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        op_valid, mem_read, mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data;
   logic        stall, misalign;
   logic [31:0] mem_data;

   mem_lsu_if #(.ADDR_W(32)) bus ();

   mem_lsu #(.ADDR_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .op_valid   (op_valid),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .funct3     (funct3),
      .addr       (addr),
      .store_data (store_data),
      .stall      (stall),
      .misalign   (misalign),
      .mem_data   (mem_data),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference memory (bytes) and the bus slave's backing store (words).
   logic [7:0]  ref_mem [int unsigned];
   logic [31:0] bus_mem [int unsigned];
   logic [31:0] last_ld = 32'h0;

   // Observations of the most recent op.
   int          ob_stall, ob_mis, ob_req;
   logic        ob_held, ob_timeout, ob_first_stall, ob_we;
   logic [31:0] ob_addr, ob_wdata, ob_mem_data;
   logic [3:0]  ob_wstrb;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   function automatic logic [31:0] bus_rd(input logic [31:0] a);
      return bus_mem.exists(a >> 2) ? bus_mem[a >> 2] : 32'h0;
   endfunction

   function automatic void preload(input logic [31:0] a, input logic [31:0] w);
      bus_mem[a >> 2] = w;
      for (int i = 0; i < 4; i++) ref_mem[a + i] = w[8*i +: 8];
   endfunction

   task automatic bus_idle();
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_rdata = 32'h0;
   endtask

   // Present one op, act as the memory slave, and record what the DUT did
   // until the pipeline advances (first cycle with stall low).
   task automatic run_op(input logic ov, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input int rw, input int sw, input bit spur);
      int          rdy_cnt = 0, rsp_cnt = 0;
      bit          pending = 0, hs, rsp_taken, fin = 0;
      logic [31:0] pend_addr = 0;
      ob_stall = 0; ob_mis = 0; ob_req = 0; ob_held = 1'b1; ob_timeout = 1'b1;
      op_valid = ov; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
      for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
         bus_idle();
         bus.req_ready = bus.req_valid && (rdy_cnt >= rw);
         bus.rsp_rdata = 32'hBAD0_BAD0;
         if (pending && rsp_cnt >= sw) begin
            bus.rsp_valid = 1'b1;
            bus.rsp_rdata = bus_rd(pend_addr);
         end else if (spur && bus.req_valid) begin
            bus.rsp_valid = 1'b1;
         end
         @(negedge clk);
         if (cyc == 0) ob_first_stall = stall;
         if (stall) ob_stall++;
         if (misalign) ob_mis++;
         if (bus.req_valid) begin
            if (ob_req == 0) begin
               ob_addr = bus.req_addr; ob_we = bus.req_we;
               ob_wstrb = bus.req_wstrb; ob_wdata = bus.req_wdata;
            end else if (bus.req_addr !== ob_addr || bus.req_we !== ob_we ||
                         bus.req_wstrb !== ob_wstrb || bus.req_wdata !== ob_wdata) begin
               ob_held = 1'b0;
            end
            ob_req++;
         end
         hs        = bus.req_valid && bus.req_ready;
         rsp_taken = pending && bus.rsp_valid;
         if (!stall) begin
            ob_mem_data = mem_data;
            ob_timeout  = 1'b0;
            fin         = 1;
         end
         @(posedge clk); #1;
         if (bus.req_valid === 1'b0 && hs) begin
            if (ob_we) begin
               logic [31:0] w;
               w = bus_rd(ob_addr);
               for (int k = 0; k < 4; k++) if (ob_wstrb[k]) w[8*k +: 8] = ob_wdata[8*k +: 8];
               bus_mem[ob_addr >> 2] = w;
            end else begin
               pending = 1; pend_addr = ob_addr;
            end
         end
         if (!hs && ob_req > 0 && pending == 0) rdy_cnt++;
         if (rsp_taken) pending = 0;
         else if (pending && !hs) rsp_cnt++;
      end
      op_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      bus_idle();
   endtask

   // Run an op and compare everything against the byte-level memory model.
   task automatic exec(input string tag, input logic ov, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                       input int rw, input int sw, input bit spur);
      int          size;
      bit          is_mem, mis;
      logic [31:0] exp_ld, exp_wd;
      logic [3:0]  exp_strb;
      run_op(ov, rd, wr, f3, a, sd, rw, sw, spur);
      size   = 1 << f3[1:0];
      is_mem = ov && (rd || wr);
      mis    = is_mem && ((size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00));
      check({tag, ":timeout"}, 32'(ob_timeout), 32'h0);
      check({tag, ":misalign"}, ob_mis, 32'(mis));
      if (!is_mem || mis) begin
         check({tag, ":stall"}, ob_stall, 0);
         check({tag, ":req"}, ob_req, 0);
         check({tag, ":mem_data"}, ob_mem_data, last_ld);
      end else begin
         check({tag, ":req_addr"}, ob_addr, a & 32'hFFFF_FFFC);
         check({tag, ":req_we"}, 32'(ob_we), 32'(wr));
         check({tag, ":req_cycles"}, ob_req, 1 + rw);
         check({tag, ":held"}, 32'(ob_held), 32'h1);
         exp_strb = 4'b0000;
         exp_wd   = 32'h0;
         if (wr) begin
            for (int i = 0; i < size; i++) exp_strb[a[1:0] + i] = 1'b1;
            for (int k = 0; k < 4; k++) exp_wd[8*k +: 8] = sd[8*(k % size) +: 8];
            for (int i = 0; i < size; i++) ref_mem[a + i] = sd[8*i +: 8];
            check({tag, ":wdata"}, ob_wdata, exp_wd);
            check({tag, ":stall"}, ob_stall, 2 + rw);
            check({tag, ":mem_data"}, ob_mem_data, last_ld);
         end else begin
            exp_ld = 32'h0;
            for (int i = 0; i < size; i++) exp_ld[8*i +: 8] = ref_rd(a + i);
            if (!f3[2] && size < 4 && exp_ld[8*size-1])
               for (int b = 8*size; b < 32; b++) exp_ld[b] = 1'b1;
            check({tag, ":stall"}, ob_stall, 3 + rw + sw);
            check({tag, ":mem_data"}, ob_mem_data, exp_ld);
            last_ld = exp_ld;
         end
         check({tag, ":wstrb"}, 32'(ob_wstrb), 32'(exp_strb));
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, ":stall"}, 32'(stall), 32'h0);
      check({tag, ":misalign"}, 32'(misalign), 32'h0);
      check({tag, ":req_valid"}, 32'(bus.req_valid), 32'h0);
      check({tag, ":mem_data"}, mem_data, 32'h0);
      check({tag, ":req_addr"}, bus.req_addr, 32'h0);
      check({tag, ":req_we"}, 32'(bus.req_we), 32'h0);
      check({tag, ":req_wstrb"}, 32'(bus.req_wstrb), 32'h0);
      check({tag, ":req_wdata"}, bus.req_wdata, 32'h0);
   endtask

   initial begin
      logic [2:0] ld_f3 [5];
      logic [2:0] st_f3 [3];
      ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      st_f3 = '{3'b000, 3'b001, 3'b010};

      rst_n = 1'b0;
      op_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      funct3 = 3'b000; addr = 32'h0; store_data = 32'h0;
      bus_idle();
      @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // LW, zero-wait bus.
      preload(32'h100, 32'hDEAD_BEEF);
      exec("lw", 1, 1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 0);
      check("lw:lit_data", ob_mem_data, 32'hDEAD_BEEF);
      check("lw:lit_stall", ob_stall, 3);
      check("lw:lit_addr", ob_addr, 32'h100);

      // Byte/half extraction and extension.
      preload(32'h100, 32'h80FF_FF7F);
      exec("lb", 1, 1, 0, 3'b000, 32'h103, 32'h0, 0, 0, 0);
      check("lb:lit", ob_mem_data, 32'hFFFF_FF80);
      exec("lbu", 1, 1, 0, 3'b100, 32'h103, 32'h0, 0, 0, 0);
      check("lbu:lit", ob_mem_data, 32'h0000_0080);
      exec("lh", 1, 1, 0, 3'b001, 32'h102, 32'h0, 0, 0, 0);
      check("lh:lit", ob_mem_data, 32'hFFFF_80FF);
      exec("lhu", 1, 1, 0, 3'b101, 32'h102, 32'h0, 1, 2, 0);
      check("lhu:lit", ob_mem_data, 32'h0000_80FF);

      // SB with three cycles of back-pressure.
      exec("sb", 1, 0, 1, 3'b000, 32'h201, 32'h1234_5678, 3, 0, 0);
      check("sb:lit_wstrb", 32'(ob_wstrb), 32'h2);
      check("sb:lit_wdata", ob_wdata, 32'h7878_7878);
      check("sb:lit_stall", ob_stall, 5);

      // Misaligned accesses.
      exec("sw_mis", 1, 0, 1, 3'b010, 32'h102, 32'hAAAA_5555, 0, 0, 0);
      exec("sh_mis", 1, 0, 1, 3'b001, 32'h101, 32'hAAAA_5555, 0, 0, 0);
      exec("lw_mis", 1, 1, 0, 3'b010, 32'h101, 32'h0, 0, 0, 0);

      // Non-memory op and invalid op.
      exec("alu", 1, 0, 0, 3'b010, 32'h100, 32'h0, 0, 0, 0);
      exec("inval", 0, 1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 0);

      // Load with spurious responses during REQ, then an immediate store.
      exec("lw_spur", 1, 1, 0, 3'b010, 32'h100, 32'h0, 2, 1, 1);
      check("lw_spur:lit", ob_mem_data, 32'h80FF_FF7F);
      exec("sw_b2b", 1, 0, 1, 3'b010, 32'h104, 32'hCAFE_0001, 0, 0, 1);
      check("sw_b2b:first_stall", 32'(ob_first_stall), 32'h1);
      exec("lw_back", 1, 1, 0, 3'b010, 32'h104, 32'h0, 0, 0, 0);
      check("lw_back:lit", ob_mem_data, 32'hCAFE_0001);

      // Reset while the load waits for its response.
      preload(32'h300, 32'h1357_9BDF);
      op_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h300;
      @(posedge clk); #1;
      check("rst_mid:in_req", 32'(bus.req_valid), 32'h1);
      bus.req_ready = 1'b1;
      @(posedge clk); #1;
      bus.req_ready = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check_zero("rst_mid");
      @(posedge clk); #1;
      rst_n = 1'b1; op_valid = 1'b0; mem_read = 1'b0;
      bus.rsp_valid = 1'b1; bus.rsp_rdata = 32'h1357_9BDF;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_after:stall", 32'(stall), 32'h0);
         check("rst_after:req_valid", 32'(bus.req_valid), 32'h0);
         check("rst_after:mem_data", mem_data, 32'h0);
         @(posedge clk); #1;
      end
      bus_idle();
      last_ld = 32'h0;

      // Randomized mix against the memory model.
      for (int n = 0; n < 60; n++) begin
         int          kind;
         logic [31:0] a, sd;
         kind = $urandom_range(0, 9);
         a    = 32'h400 + $urandom_range(0, 31);
         sd   = $urandom;
         if (kind == 0)
            exec("rnd_alu", $urandom_range(0, 1) == 1, 0, 0, 3'b010, a, sd, 0, 0, 0);
         else if (kind == 1)
            exec("rnd_inval", 0, 1, 0, 3'b000, a, sd, 0, 0, 0);
         else if (kind < 6)
            exec("rnd_ld", 1, 1, 0, ld_f3[$urandom_range(0, 4)], a, sd,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1);
         else
            exec("rnd_st", 1, 0, 1, st_f3[$urandom_range(0, 2)], a, sd,
                 $urandom_range(0, 3), 0, $urandom_range(0, 1) == 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
